// File: rtl/dma_pkg.sv
// ---------------------------------------------------------------------------
// dma_pkg
//   Shared types and constants for the DMA memory-side endpoint.
//   - mem_port_state_t : transaction FSM states of dma_mem_port
//   - BYTES_PER_WORD   : bytes per memory word for the default 16-bit bus
//   - BYTE_SHIFT       : log2(BYTES_PER_WORD), byte -> word address shift
//   - byte_shift()     : same shift for an arbitrary data width
// ---------------------------------------------------------------------------
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_RD_RESP  = 3'd3,
      ST_WR_ISSUE = 3'd4,
      ST_WR_ACK   = 3'd5
   } mem_port_state_t;

   localparam int DMA_DATA_WIDTH = 16;
   localparam int BYTES_PER_WORD = DMA_DATA_WIDTH / 8;
   localparam int BYTE_SHIFT     = $clog2(BYTES_PER_WORD);

   function automatic int byte_shift(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/dma_addr_decode.sv
// ---------------------------------------------------------------------------
// dma_addr_decode
//   Combinational byte-address to memory word-address translation.
//   Ports:
//     byte_addr    in   ADDR_WIDTH  DMA byte address
//     word_addr    out  MEM_AW      word address (low byte bits dropped)
//     misalign     out  1           byte address not on a word boundary
//     out_of_range out  1           full word index >= MEM_DEPTH
// ---------------------------------------------------------------------------
module dma_addr_decode
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_AW     = 18,
   parameter int MEM_DEPTH  = 2**18
) (
   input  logic [ADDR_WIDTH-1:0] byte_addr,
   output logic [MEM_AW-1:0]     word_addr,
   output logic                  misalign,
   output logic                  out_of_range
);

   localparam int SHIFT = byte_shift(DATA_WIDTH);
   localparam int BPW   = DATA_WIDTH / 8;

   logic [ADDR_WIDTH-1:0] word_full;

   always_comb begin
      word_full    = byte_addr >> SHIFT;
      word_addr    = word_full[MEM_AW-1:0];
      // Mask is zero for byte-wide words, so misalign can never fire there.
      misalign     = (byte_addr & ADDR_WIDTH'(BPW - 1)) != '0;
      // Range is judged on the untruncated index so high address bits count.
      out_of_range = 64'(word_full) >= 64'(MEM_DEPTH);
   end

endmodule

// File: rtl/dma_mem_port.sv
// ---------------------------------------------------------------------------
// dma_mem_port
//   Memory-side endpoint of the DMA controller. Converts level-held read and
//   write requests into single-beat req/gnt transactions on a shared
//   single-port memory with fixed read latency. One transaction in flight.
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     dma_read_req/addr                level read request, byte address
//     dma_read_data/valid              read data with 1-cycle valid pulse
//     dma_write_req/addr/data          level write request
//     dma_write_ack                    1-cycle completion pulse
//     mem_req/we/addr/wdata, mem_gnt   registered memory request, grant
//     mem_rdata                        read data RD_LATENCY cycles after gnt
//     err_align, err_range             sticky address error flags
//     rd_count, wr_count               wrapping completion counters
// ---------------------------------------------------------------------------
module dma_mem_port
   import dma_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_AW     = 18,
   parameter int MEM_DEPTH  = 2**18,
   parameter int RD_LATENCY = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  dma_read_req,
   input  logic [ADDR_WIDTH-1:0] dma_read_addr,
   output logic [DATA_WIDTH-1:0] dma_read_data,
   output logic                  dma_read_valid,
   input  logic                  dma_write_req,
   input  logic [ADDR_WIDTH-1:0] dma_write_addr,
   input  logic [DATA_WIDTH-1:0] dma_write_data,
   output logic                  dma_write_ack,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [MEM_AW-1:0]     mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  mem_gnt,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   output logic                  err_align,
   output logic                  err_range,
   output logic [31:0]           rd_count,
   output logic [31:0]           wr_count
);

   localparam logic [3:0] LAT_INIT = 4'(RD_LATENCY - 1);

   mem_port_state_t       state;
   logic [3:0]            lat_cnt;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [MEM_AW-1:0]     dec_word_addr;
   logic                  dec_misalign;
   logic                  dec_range;

   // Read has priority; the decoder only matters on the IDLE accept cycle.
   assign sel_addr = dma_read_req ? dma_read_addr : dma_write_addr;

   dma_addr_decode #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .MEM_AW     (MEM_AW),
      .MEM_DEPTH  (MEM_DEPTH)
   ) u_addr_decode (
      .byte_addr    (sel_addr),
      .word_addr    (dec_word_addr),
      .misalign     (dec_misalign),
      .out_of_range (dec_range)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         lat_cnt        <= '0;
         mem_req        <= 1'b0;
         mem_we         <= 1'b0;
         mem_addr       <= '0;
         mem_wdata      <= '0;
         dma_read_data  <= '0;
         dma_read_valid <= 1'b0;
         dma_write_ack  <= 1'b0;
         err_align      <= 1'b0;
         err_range      <= 1'b0;
         rd_count       <= '0;
         wr_count       <= '0;
      end else begin
         dma_read_valid <= 1'b0;
         dma_write_ack  <= 1'b0;
         case (state)
            ST_IDLE: begin
               // A valid/ack pulse still showing means the DMA has not yet
               // had an edge to advance its address; hold off one cycle so
               // the old address is never fetched twice.
               if (!dma_read_valid && !dma_write_ack &&
                   (dma_read_req || dma_write_req)) begin
                  mem_addr  <= dec_word_addr;
                  mem_we    <= !dma_read_req;
                  mem_wdata <= dma_write_data;
                  if (dec_misalign) err_align <= 1'b1;
                  if (dec_range) begin
                     // Out-of-range: complete locally without touching the bus.
                     err_range <= 1'b1;
                     if (dma_read_req) begin
                        dma_read_data <= '0;
                        state         <= ST_RD_RESP;
                     end else begin
                        state         <= ST_WR_ACK;
                     end
                  end else begin
                     mem_req <= 1'b1;
                     state   <= dma_read_req ? ST_RD_ISSUE : ST_WR_ISSUE;
                  end
               end
            end
            ST_RD_ISSUE: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  lat_cnt <= LAT_INIT;
                  state   <= ST_RD_WAIT;
               end
            end
            ST_RD_WAIT: begin
               if (lat_cnt == 4'd0) begin
                  dma_read_data <= mem_rdata;
                  state         <= ST_RD_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 4'd1;
               end
            end
            ST_RD_RESP: begin
               dma_read_valid <= 1'b1;
               rd_count       <= rd_count + 32'd1;
               state          <= ST_IDLE;
            end
            ST_WR_ISSUE: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  state   <= ST_WR_ACK;
               end
            end
            ST_WR_ACK: begin
               dma_write_ack <= 1'b1;
               wr_count      <= wr_count + 32'd1;
               state         <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dma_mem_port.sv
// ---------------------------------------------------------------------------
// tb_dma_mem_port
//   Self-checking bench for dma_mem_port: memory model with controllable
//   grant, scoreboard of expected completions, table of basic transactions
//   and hand-written sequences for stalls, priority, errors, bursts, reset.
// ---------------------------------------------------------------------------
module tb_dma_mem_port;
   import dma_pkg::*;

   localparam int DW    = 16;
   localparam int AW    = 32;
   localparam int MAW   = 18;
   localparam int DEPTH = 2**18;
   localparam int RDL   = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           dma_read_req = 1'b0;
   logic [AW-1:0]  dma_read_addr = '0;
   logic [DW-1:0]  dma_read_data;
   logic           dma_read_valid;
   logic           dma_write_req = 1'b0;
   logic [AW-1:0]  dma_write_addr = '0;
   logic [DW-1:0]  dma_write_data = '0;
   logic           dma_write_ack;
   logic           mem_req;
   logic           mem_we;
   logic [MAW-1:0] mem_addr;
   logic [DW-1:0]  mem_wdata;
   logic           mem_gnt;
   logic [DW-1:0]  mem_rdata;
   logic           err_align;
   logic           err_range;
   logic [31:0]    rd_count;
   logic [31:0]    wr_count;

   logic gnt_allow = 1'b1;
   assign mem_gnt = mem_req & gnt_allow;

   always #5 clk = ~clk;

   dma_mem_port #(
      .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .MEM_AW (MAW),
      .MEM_DEPTH (DEPTH), .RD_LATENCY (RDL)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .dma_read_req (dma_read_req), .dma_read_addr (dma_read_addr),
      .dma_read_data (dma_read_data), .dma_read_valid (dma_read_valid),
      .dma_write_req (dma_write_req), .dma_write_addr (dma_write_addr),
      .dma_write_data (dma_write_data), .dma_write_ack (dma_write_ack),
      .mem_req (mem_req), .mem_we (mem_we), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_gnt (mem_gnt), .mem_rdata (mem_rdata),
      .err_align (err_align), .err_range (err_range),
      .rd_count (rd_count), .wr_count (wr_count)
   );

   // Memory model: unwritten words hold index ^ 0x3C3C.
   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] rd_q [RDL];
   bit            mem_ready = 1'b0;

   function automatic logic [DW-1:0] pattern(input int idx);
      return 16'(idx) ^ 16'h3C3C;
   endfunction

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= pattern(i);
         mem[8]       <= 16'hBEEF;
         mem[DEPTH-1] <= 16'hC0DE;
         mem_ready    <= 1'b1;
      end else if (mem_req && mem_gnt && mem_we) begin
         mem[mem_addr] <= mem_wdata;
      end
      rd_q[0] <= (mem_req && mem_gnt && !mem_we) ? mem[mem_addr] : 16'hDEAD;
      for (int i = 1; i < RDL; i++) rd_q[i] <= rd_q[i-1];
   end
   assign mem_rdata = rd_q[RDL-1];

   // Scoreboard
   typedef struct {
      bit            is_wr;
      logic [DW-1:0] data;
   } exp_t;
   exp_t sbq[$];

   int n_cmp = 0;
   int n_bad = 0;
   int n_valid = 0;
   int mreq_cycles = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic fail_now(input string name);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timed out (t=%0t)", name, $time);
   endtask

   // Pre-edge bus state for the stall-hold check
   logic           pre_req, pre_gnt, pre_we;
   logic [MAW-1:0] pre_addr;
   logic [DW-1:0]  pre_wdata;
   always @(posedge clk) begin
      pre_req   <= mem_req;
      pre_gnt   <= mem_gnt;
      pre_we    <= mem_we;
      pre_addr  <= mem_addr;
      pre_wdata <= mem_wdata;
   end

   always @(negedge clk) begin : monitor
      exp_t e;
      if (mem_req) mreq_cycles++;
      if (dma_read_valid) begin
         n_valid++;
         if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_unexpected: got valid data %0h, expected none", dma_read_data);
         end else begin
            e = sbq.pop_front();
            check("rd_order", 64'(e.is_wr), 64'(0));
            check("rd_data", 64'(dma_read_data), 64'(e.data));
         end
      end
      if (dma_write_ack) begin
         if (sbq.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_unexpected: got ack, expected none");
         end else begin
            e = sbq.pop_front();
            check("wr_order", 64'(e.is_wr), 64'(1));
         end
      end
      if (rst_n && pre_req && !pre_gnt) begin
         check("hold_req", 64'(mem_req), 64'(1));
         check("hold_we", 64'(mem_we), 64'(pre_we));
         check("hold_addr", 64'(mem_addr), 64'(pre_addr));
         check("hold_wdata", 64'(mem_wdata), 64'(pre_wdata));
      end
   end

   // Drive one transaction; cycles = accept edge to valid/ack visible.
   task automatic do_txn(input bit is_wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] expd,
                         output int cycles);
      exp_t e;
      int   n;
      bit   done;
      e.is_wr = is_wr;
      e.data  = expd;
      sbq.push_back(e);
      @(negedge clk);
      if (is_wr) begin
         dma_write_addr = addr; dma_write_data = wdata; dma_write_req = 1'b1;
      end else begin
         dma_read_addr = addr; dma_read_req = 1'b1;
      end
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         done = is_wr ? dma_write_ack : dma_read_valid;
      end
      if (!done) fail_now("txn_wait");
      dma_read_req  = 1'b0;
      dma_write_req = 1'b0;
      cycles = n - 1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   typedef struct {
      bit            is_wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [DW-1:0] expd;
   } vec_t;
   vec_t tv[9];

   initial begin : main
      int lat, v0, m0, w;
      bit got_v, got_a, ok;

      tv[0] = '{1'b0, 32'h0000_0010, 16'h0000, 16'hBEEF};
      tv[1] = '{1'b1, 32'h0000_0040, 16'h5A5A, 16'h0000};
      tv[2] = '{1'b0, 32'h0000_0040, 16'h0000, 16'h5A5A};
      tv[3] = '{1'b1, 32'h0000_0000, 16'h0001, 16'h0000};
      tv[4] = '{1'b0, 32'h0000_0000, 16'h0000, 16'h0001};
      tv[5] = '{1'b0, 32'h0007_FFFE, 16'h0000, 16'hC0DE};
      tv[6] = '{1'b0, 32'h0000_0022, 16'h0000, 16'h3C2D};
      tv[7] = '{1'b1, 32'h0007_FFFE, 16'hA0A0, 16'h0000};
      tv[8] = '{1'b0, 32'h0007_FFFE, 16'h0000, 16'hA0A0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_mem_req", 64'(mem_req), 64'(0));
      check("rst_mem_we", 64'(mem_we), 64'(0));
      check("rst_mem_addr", 64'(mem_addr), 64'(0));
      check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
      check("rst_rd_valid", 64'(dma_read_valid), 64'(0));
      check("rst_rd_data", 64'(dma_read_data), 64'(0));
      check("rst_wr_ack", 64'(dma_write_ack), 64'(0));
      check("rst_err_align", 64'(err_align), 64'(0));
      check("rst_err_range", 64'(err_range), 64'(0));
      check("rst_rd_count", 64'(rd_count), 64'(0));
      check("rst_wr_count", 64'(wr_count), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Table of basic transactions, grant tied high
      for (int i = 0; i < 9; i++) begin
         do_txn(tv[i].is_wr, tv[i].addr, tv[i].wdata, tv[i].expd, lat);
         check($sformatf("tv%0d_latency", i), 64'(lat), 64'(tv[i].is_wr ? 2 : RDL + 2));
      end
      check("tv_rd_count", 64'(rd_count), 64'(6));
      check("tv_wr_count", 64'(wr_count), 64'(3));
      check("tv_err_align", 64'(err_align), 64'(0));
      check("tv_err_range", 64'(err_range), 64'(0));

      // Write with grant stalled for 3 cycles
      sbq.push_back('{1'b1, 16'h0000});
      gnt_allow = 1'b0;
      @(negedge clk);
      dma_write_addr = 32'h20; dma_write_data = 16'h1234; dma_write_req = 1'b1;
      w = 0;
      while (!mem_req && w < 20) begin @(negedge clk); w++; end
      if (!mem_req) fail_now("stall_req_wait");
      for (int i = 0; i < 3; i++) begin
         check("stall_req", 64'(mem_req), 64'(1));
         check("stall_we", 64'(mem_we), 64'(1));
         check("stall_addr", 64'(mem_addr), 64'(18'h10));
         check("stall_wdata", 64'(mem_wdata), 64'(16'h1234));
         if (i < 2) @(negedge clk);
      end
      gnt_allow = 1'b1;
      @(negedge clk);
      check("stall_req_drop", 64'(mem_req), 64'(0));
      check("stall_ack_early", 64'(dma_write_ack), 64'(0));
      @(negedge clk);
      check("stall_ack", 64'(dma_write_ack), 64'(1));
      dma_write_req = 1'b0;
      check("stall_mem", 64'(mem[16'h10]), 64'(16'h1234));

      // Read and write raised together: read first, then write
      sbq.push_back('{1'b0, 16'hBEEF});
      sbq.push_back('{1'b1, 16'h0000});
      @(negedge clk);
      dma_read_addr = 32'h10; dma_write_addr = 32'h30; dma_write_data = 16'h7777;
      dma_read_req = 1'b1; dma_write_req = 1'b1;
      got_v = 1'b0; got_a = 1'b0; w = 0;
      while (!got_a && w < 60) begin
         @(negedge clk);
         w++;
         if (dma_read_valid) begin got_v = 1'b1; dma_read_req = 1'b0; end
         if (dma_write_ack) begin got_a = 1'b1; dma_write_req = 1'b0; end
      end
      if (!got_a) fail_now("both_wait");
      dma_read_req = 1'b0; dma_write_req = 1'b0;
      check("both_read_seen", 64'(got_v), 64'(1));
      check("both_mem", 64'(mem[16'h18]), 64'(16'h7777));

      // Misaligned address: truncated to word 8
      do_txn(1'b0, 32'h11, 16'h0, 16'hBEEF, lat);
      check("align_flag", 64'(err_align), 64'(1));
      check("align_no_range", 64'(err_range), 64'(0));
      check("align_word", 64'(mem_addr), 64'(8));

      // Out-of-range read and write: complete without any bus request
      m0 = mreq_cycles;
      do_txn(1'b0, 32'(2 * DEPTH * BYTES_PER_WORD), 16'h0, 16'h0000, lat);
      check("range_flag", 64'(err_range), 64'(1));
      check("range_no_req", 64'(mreq_cycles), 64'(m0));
      v0 = int'(wr_count);
      do_txn(1'b1, 32'(DEPTH * BYTES_PER_WORD), 16'hFFFF, 16'h0, lat);
      check("range_wr_no_req", 64'(mreq_cycles), 64'(m0));
      check("range_wr_count", 64'(wr_count), 64'(v0 + 1));

      // Reset clears flags and counters; then a 9-word DMA burst
      do_reset();
      check("rst2_err_align", 64'(err_align), 64'(0));
      check("rst2_err_range", 64'(err_range), 64'(0));
      check("rst2_rd_count", 64'(rd_count), 64'(0));
      v0 = n_valid;
      for (int k = 0; k < 9; k++) sbq.push_back('{1'b0, pattern(16'h80 + k)});
      @(negedge clk);
      dma_read_addr = 32'h100; dma_read_req = 1'b1;
      ok = 1'b1;
      for (int k = 0; k < 9 && ok; k++) begin
         w = 0;
         while (!dma_read_valid && w < 50) begin @(negedge clk); w++; end
         if (!dma_read_valid) begin fail_now("burst_wait"); ok = 1'b0; end
         // DMA advances its address on the edge after it sees valid
         @(posedge clk);
         #1;
         if (k == 8) dma_read_req = 1'b0;
         else dma_read_addr = dma_read_addr + 32'd2;
      end
      dma_read_req = 1'b0;
      repeat (4) @(negedge clk);
      check("burst_valids", 64'(n_valid - v0), 64'(9));
      check("burst_rd_count", 64'(rd_count), 64'(9));

      // Reset while waiting on read latency
      v0 = n_valid;
      @(negedge clk);
      dma_read_addr = 32'h10; dma_read_req = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      @(negedge clk);
      dma_read_req = 1'b0;
      check("abort_mem_req", 64'(mem_req), 64'(0));
      check("abort_valid", 64'(dma_read_valid), 64'(0));
      check("abort_rd_data", 64'(dma_read_data), 64'(0));
      check("abort_rd_count", 64'(rd_count), 64'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      check("abort_no_valid", 64'(n_valid), 64'(v0));
      do_txn(1'b0, 32'h10, 16'h0, 16'hBEEF, lat);
      check("abort_next_lat", 64'(lat), 64'(RDL + 2));
      check("abort_next_count", 64'(rd_count), 64'(1));

      repeat (2) @(negedge clk);
      check("sb_empty", 64'(sbq.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
